// File: rtl/i4003_loader.sv
// i4003_loader
//   Serially loads a parallel word into a chain of cascaded i4003 shift
//   registers. A host hands over a word with a valid/ready handshake; the
//   block shifts it out with fixed cp low/high widths and pulses done when
//   the chain holds the whole word.
//
// Ports
//   sysclk      system clock, rising edge
//   reset_n     asynchronous active-low reset
//   load_valid  host offers load_word
//   load_word   word to shift out (WIDTH bits)
//   load_ready  block accepts a word this cycle
//   busy        shift sequence in progress
//   done        one-cycle pulse at the end of a load
//   sr_data     serial data to i4003 serial_in
//   sr_cp       shift clock to i4003 cp (chain samples on its rising edge)
//   sr_enable   i4003 output enable
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for load_valid; load_ready high
// LOW     | sr_cp low, current bit stable on sr_data
// HIGH    | sr_cp high, chain samples the bit on entry
// LATCH   | all bits shifted; done pulse, outputs re-enabled
module i4003_loader #(
  parameter int WIDTH       = 10,
  parameter int LOW_CYCLES  = 2,
  parameter int HIGH_CYCLES = 2,
  parameter int LSB_FIRST   = 0,
  parameter int BLANK       = 1
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_word,
  output logic             load_ready,
  output logic             busy,
  output logic             done,
  output logic             sr_data,
  output logic             sr_cp,
  output logic             sr_enable
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOW   = 2'd1;
  localparam logic [1:0] S_HIGH  = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  localparam int BW   = $clog2(WIDTH + 1);
  localparam int MAXC = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
  localparam int PW   = $clog2(MAXC + 1);

  localparam logic [BW-1:0] WIDTH_C = BW'(WIDTH);
  localparam logic [PW-1:0] LOW_LD  = PW'(LOW_CYCLES - 1);
  localparam logic [PW-1:0] HIGH_LD = PW'(HIGH_CYCLES - 1);

  logic [1:0]       state;
  logic [BW-1:0]    bit_cnt;
  logic [PW-1:0]    phase;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;

  // The bit currently on sr_data always sits at the outgoing end of shreg.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
  endfunction

  assign shifted = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      phase      <= '0;
      shreg      <= '0;
      load_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sr_data    <= 1'b0;
      sr_cp      <= 1'b0;
      sr_enable  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          load_ready <= 1'b1;
          busy       <= 1'b0;
          sr_cp      <= 1'b0;
          if (BLANK == 0) sr_enable <= 1'b1;
          if (load_valid && load_ready) begin
            shreg      <= load_word;
            sr_data    <= first_bit(load_word);
            bit_cnt    <= '0;
            phase      <= LOW_LD;
            state      <= S_LOW;
            load_ready <= 1'b0;
            busy       <= 1'b1;
            if (BLANK != 0) sr_enable <= 1'b0;
          end
        end
        S_LOW: begin
          if (phase == '0) begin
            phase <= HIGH_LD;
            sr_cp <= 1'b1;
            state <= S_HIGH;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        S_HIGH: begin
          if (phase == '0) begin
            bit_cnt <= bit_cnt + 1'b1;
            sr_cp   <= 1'b0;
            if (bit_cnt + 1'b1 == WIDTH_C) begin
              state     <= S_LATCH;
              done      <= 1'b1;
              sr_enable <= 1'b1;
            end else begin
              // Next bit goes out on the cp falling edge, giving a full low
              // phase of setup before the next rise.
              shreg   <= shifted;
              sr_data <= first_bit(shifted);
              phase   <= LOW_LD;
              state   <= S_LOW;
            end
          end else begin
            phase <= phase - 1'b1;
          end
        end
        S_LATCH: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          load_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i4003_loader.sv
module tb_i4003_loader;

  logic sysclk = 1'b0;
  logic reset_n = 1'b0;
  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  // default instance: WIDTH 10, L2 H2, MSB first, BLANK 1
  logic       def_valid = 1'b0;
  logic [9:0] def_word = '0;
  logic def_ready, def_busy, def_done, def_data, def_cp, def_en;
  // LSB first, L3 H1
  logic       lsb_valid = 1'b0;
  logic [9:0] lsb_word = '0;
  logic lsb_ready, lsb_busy, lsb_done, lsb_data, lsb_cp, lsb_en;
  // BLANK 0
  logic       nb_valid = 1'b0;
  logic [9:0] nb_word = '0;
  logic nb_ready, nb_busy, nb_done, nb_data, nb_cp, nb_en;
  // WIDTH 1, BLANK 0
  logic       w1_valid = 1'b0;
  logic [0:0] w1_word = '0;
  logic w1_ready, w1_busy, w1_done, w1_data, w1_cp, w1_en;

  i4003_loader #(.WIDTH(10), .LOW_CYCLES(2), .HIGH_CYCLES(2), .LSB_FIRST(0), .BLANK(1)) u_def (
    .sysclk(sysclk), .reset_n(reset_n), .load_valid(def_valid), .load_word(def_word),
    .load_ready(def_ready), .busy(def_busy), .done(def_done), .sr_data(def_data),
    .sr_cp(def_cp), .sr_enable(def_en));
  i4003_loader #(.WIDTH(10), .LOW_CYCLES(3), .HIGH_CYCLES(1), .LSB_FIRST(1), .BLANK(1)) u_lsb (
    .sysclk(sysclk), .reset_n(reset_n), .load_valid(lsb_valid), .load_word(lsb_word),
    .load_ready(lsb_ready), .busy(lsb_busy), .done(lsb_done), .sr_data(lsb_data),
    .sr_cp(lsb_cp), .sr_enable(lsb_en));
  i4003_loader #(.WIDTH(10), .LOW_CYCLES(2), .HIGH_CYCLES(2), .LSB_FIRST(0), .BLANK(0)) u_nb (
    .sysclk(sysclk), .reset_n(reset_n), .load_valid(nb_valid), .load_word(nb_word),
    .load_ready(nb_ready), .busy(nb_busy), .done(nb_done), .sr_data(nb_data),
    .sr_cp(nb_cp), .sr_enable(nb_en));
  i4003_loader #(.WIDTH(1), .LOW_CYCLES(2), .HIGH_CYCLES(2), .LSB_FIRST(0), .BLANK(0)) u_w1 (
    .sysclk(sysclk), .reset_n(reset_n), .load_valid(w1_valid), .load_word(w1_word),
    .load_ready(w1_ready), .busy(w1_busy), .done(w1_done), .sr_data(w1_data),
    .sr_cp(w1_cp), .sr_enable(w1_en));

  // Model i4003 chains: shift in on cp rise, first bit ends up at the MSB.
  logic [9:0] def_par = '0, lsb_par = '0, nb_par = '0;
  logic       w1_par = 1'b0;
  int def_rises = 0, lsb_rises = 0, nb_rises = 0, w1_rises = 0;
  int def_dones = 0, nb_en_low = 0;

  always @(posedge def_cp) begin def_par <= {def_par[8:0], def_data}; def_rises <= def_rises + 1; end
  always @(posedge lsb_cp) begin lsb_par <= {lsb_par[8:0], lsb_data}; lsb_rises <= lsb_rises + 1; end
  always @(posedge nb_cp)  begin nb_par  <= {nb_par[8:0], nb_data};   nb_rises  <= nb_rises + 1;  end
  always @(posedge w1_cp)  begin w1_par  <= w1_data;                  w1_rises  <= w1_rises + 1;  end

  always @(posedge sysclk) begin
    if (def_done) def_dones <= def_dones + 1;
    if (!nb_en) nb_en_low <= nb_en_low + 1;
  end

  // cp run-length and data-stability tracking for the L3/H1 instance
  logic lsb_prev_cp = 1'b0, lsb_prev_data = 1'b0, lsb_start_ok = 1'b0;
  int lsb_run = 0, lsb_bad_hi = 0, lsb_bad_lo = 0, lsb_bad_data = 0, lsb_hi_runs = 0, lsb_lo_runs = 0;

  always @(posedge sysclk) begin
    if (lsb_cp && (lsb_data != lsb_prev_data)) lsb_bad_data <= lsb_bad_data + 1;
    if (lsb_cp == lsb_prev_cp) begin
      lsb_run <= lsb_run + 1;
    end else begin
      if (lsb_prev_cp) begin
        lsb_hi_runs <= lsb_hi_runs + 1;
        if (lsb_run != 1) lsb_bad_hi <= lsb_bad_hi + 1;
      end else if (lsb_start_ok) begin
        lsb_lo_runs <= lsb_lo_runs + 1;
        if (lsb_run != 3) lsb_bad_lo <= lsb_bad_lo + 1;
      end
      lsb_run      <= 1;
      lsb_start_ok <= lsb_busy && !lsb_done;
    end
    lsb_prev_cp   <= lsb_cp;
    lsb_prev_data <= lsb_data;
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [9:0] w);
    case (i)
      0: begin def_valid = v; def_word = w; end
      1: begin lsb_valid = v; lsb_word = w; end
      2: begin nb_valid = v; nb_word = w; end
      default: begin w1_valid = v; w1_word = w[0:0]; end
    endcase
  endtask

  function automatic logic busy_of(input int i);
    case (i)
      0: return def_busy;
      1: return lsb_busy;
      2: return nb_busy;
      default: return w1_busy;
    endcase
  endfunction

  function automatic logic done_of(input int i);
    case (i)
      0: return def_done;
      1: return lsb_done;
      2: return nb_done;
      default: return w1_done;
    endcase
  endfunction

  // Offer a word until accepted, then wait for done. lat counts cycles from
  // the accept cycle to the done cycle inclusive; -1 if either never happens.
  task automatic run_word(input int i, input logic [9:0] w, output int lat);
    int acc;
    acc = -1;
    lat = -1;
    drive(i, 1'b1, w);
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (acc < 0 && busy_of(i)) begin
        acc = n;
        drive(i, 1'b0, w);
      end
      if (acc > 0 && done_of(i)) begin
        lat = n - acc + 1;
        break;
      end
    end
    drive(i, 1'b0, w);
  endtask

  task automatic test_reset();
    int base;
    reset_n = 1'b0;
    #23;
    checks++; if (def_cp !== 1'b0) begin errors++; $display("FAIL reset_cp: got %b expected 0", def_cp); end
    checks++; if (def_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", def_busy); end
    checks++; if (def_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", def_done); end
    checks++; if (def_data !== 1'b0) begin errors++; $display("FAIL reset_data: got %b expected 0", def_data); end
    checks++; if (nb_en !== 1'b0) begin errors++; $display("FAIL reset_nb_enable: got %b expected 0", nb_en); end
    @(posedge sysclk); #1;
    reset_n = 1'b1;
    tick(); tick();
    checks++; if (def_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", def_ready); end
    checks++; if ({lsb_ready, nb_ready, w1_ready} !== 3'b111) begin errors++; $display("FAIL idle_ready_others: got %b expected 111", {lsb_ready, nb_ready, w1_ready}); end
    checks++; if (def_en !== 1'b0) begin errors++; $display("FAIL idle_enable_blank: got %b expected 0", def_en); end
    checks++; if (nb_en !== 1'b1) begin errors++; $display("FAIL idle_enable_noblank: got %b expected 1", nb_en); end
    base = def_rises;
    repeat (100) tick();
    checks++; if (def_rises - base !== 0) begin errors++; $display("FAIL idle_no_cp: got %0d rises expected 0", def_rises - base); end
  endtask

  task automatic test_msb_load();
    int base, lat;
    base = def_rises;
    run_word(0, 10'h2A5, lat);
    checks++; if (lat !== 41) begin errors++; $display("FAIL msb_latency: got %0d expected 41", lat); end
    checks++; if (def_rises - base !== 10) begin errors++; $display("FAIL msb_rises: got %0d expected 10", def_rises - base); end
    checks++; if (def_par !== 10'h2A5) begin errors++; $display("FAIL msb_word: got %h expected 2a5", def_par); end
    checks++; if (def_en !== 1'b1) begin errors++; $display("FAIL msb_enable_done: got %b expected 1", def_en); end
    tick();
    checks++; if ({def_busy, def_done, def_ready} !== 3'b001) begin errors++; $display("FAIL msb_after_latch: got %b expected 001", {def_busy, def_done, def_ready}); end
  endtask

  task automatic test_lsb_timing();
    int base, lat, bh, bl, bd, hr, lr;
    base = lsb_rises; bh = lsb_bad_hi; bl = lsb_bad_lo; bd = lsb_bad_data; hr = lsb_hi_runs; lr = lsb_lo_runs;
    run_word(1, 10'h001, lat);
    tick(); tick();
    checks++; if (lat !== 41) begin errors++; $display("FAIL lsb_latency: got %0d expected 41", lat); end
    checks++; if (lsb_rises - base !== 10) begin errors++; $display("FAIL lsb_rises: got %0d expected 10", lsb_rises - base); end
    checks++; if (lsb_par !== 10'h200) begin errors++; $display("FAIL lsb_order: got %h expected 200 (first bit 1, rest 0)", lsb_par); end
    checks++; if (lsb_hi_runs - hr !== 10 || lsb_bad_hi - bh !== 0) begin errors++; $display("FAIL lsb_high_width: got %0d runs %0d bad expected 10 runs 0 bad", lsb_hi_runs - hr, lsb_bad_hi - bh); end
    checks++; if (lsb_lo_runs - lr !== 9 || lsb_bad_lo - bl !== 0) begin errors++; $display("FAIL lsb_low_width: got %0d runs %0d bad expected 9 runs 0 bad", lsb_lo_runs - lr, lsb_bad_lo - bl); end
    checks++; if (lsb_bad_data - bd !== 0) begin errors++; $display("FAIL lsb_data_while_high: got %0d changes expected 0", lsb_bad_data - bd); end
    checks++; if (lsb_en !== 1'b1) begin errors++; $display("FAIL lsb_enable_after: got %b expected 1", lsb_en); end
  endtask

  task automatic test_back_to_back();
    int base, lat, gap, bad;
    base = def_rises; lat = -1; gap = -1; bad = 0;
    drive(0, 1'b1, 10'h0C3);
    tick();
    drive(0, 1'b1, 10'h3FF);
    for (int n = 2; n <= 300; n++) begin
      tick();
      if (def_done) begin lat = n; break; end
      if (def_ready) bad++;
    end
    checks++; if (lat !== 41) begin errors++; $display("FAIL b2b_latency: got %0d expected 41", lat); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_ready_while_busy: got %0d cycles expected 0", bad); end
    checks++; if (def_par !== 10'h0C3) begin errors++; $display("FAIL b2b_first_word: got %h expected 0c3", def_par); end
    tick();
    checks++; if ({def_ready, def_busy} !== 2'b10) begin errors++; $display("FAIL b2b_idle_gap: got %b expected 10", {def_ready, def_busy}); end
    tick();
    drive(0, 1'b0, 10'h000);
    checks++; if ({def_busy, def_en} !== 2'b10) begin errors++; $display("FAIL b2b_second_accept: got %b expected 10", {def_busy, def_en}); end
    for (int n = 3; n <= 300; n++) begin
      tick();
      if (def_done) begin gap = n; break; end
    end
    checks++; if (gap !== 42) begin errors++; $display("FAIL b2b_period: got %0d expected 42", gap); end
    checks++; if (def_par !== 10'h3FF) begin errors++; $display("FAIL b2b_second_word: got %h expected 3ff", def_par); end
    checks++; if (def_rises - base !== 20) begin errors++; $display("FAIL b2b_rises: got %0d expected 20", def_rises - base); end
    tick();
  endtask

  task automatic test_reset_mid();
    int base, dbase, lat, hit;
    base = def_rises; dbase = def_dones; hit = 0;
    drive(0, 1'b1, 10'h2A5);
    tick();
    drive(0, 1'b0, 10'h2A5);
    for (int n = 0; n < 100; n++) begin
      if (def_rises - base == 4) begin hit = 1; break; end
      tick();
    end
    checks++; if (hit !== 1 || def_cp !== 1'b1 || def_busy !== 1'b1) begin errors++; $display("FAIL mid_reached_4: got hit %0d cp %b busy %b expected 1 1 1", hit, def_cp, def_busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({def_cp, def_busy, def_en, def_done} !== 4'b0000) begin errors++; $display("FAIL mid_async_clear: got %b expected 0000", {def_cp, def_busy, def_en, def_done}); end
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    checks++; if (def_dones - dbase !== 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses expected 0", def_dones - dbase); end
    checks++; if (def_rises - base !== 4) begin errors++; $display("FAIL mid_no_more_rises: got %0d expected 4", def_rises - base); end
    base = def_rises;
    run_word(0, 10'h155, lat);
    checks++; if (lat !== 41) begin errors++; $display("FAIL mid_reload_latency: got %0d expected 41", lat); end
    checks++; if (def_rises - base !== 10) begin errors++; $display("FAIL mid_reload_rises: got %0d expected 10", def_rises - base); end
    checks++; if (def_par !== 10'h155) begin errors++; $display("FAIL mid_reload_word: got %h expected 155", def_par); end
    tick();
  endtask

  task automatic test_no_blank();
    int base, elow, lat1, lat2;
    repeat (3) tick();
    base = nb_rises; elow = nb_en_low;
    run_word(2, 10'h12C, lat1);
    checks++; if (nb_par !== 10'h12C) begin errors++; $display("FAIL nb_word1: got %h expected 12c", nb_par); end
    run_word(2, 10'h2D3, lat2);
    tick();
    checks++; if (nb_par !== 10'h2D3) begin errors++; $display("FAIL nb_word2: got %h expected 2d3", nb_par); end
    checks++; if (lat1 !== 41 || lat2 !== 41) begin errors++; $display("FAIL nb_latency: got %0d %0d expected 41 41", lat1, lat2); end
    checks++; if (nb_rises - base !== 20) begin errors++; $display("FAIL nb_rises: got %0d expected 20", nb_rises - base); end
    checks++; if (nb_en_low - elow !== 0) begin errors++; $display("FAIL nb_enable_held: got %0d low cycles expected 0", nb_en_low - elow); end
  endtask

  task automatic test_width1();
    int base, lat;
    base = w1_rises;
    run_word(3, 10'h001, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL w1_latency: got %0d expected 5", lat); end
    checks++; if (w1_rises - base !== 1) begin errors++; $display("FAIL w1_rises: got %0d expected 1", w1_rises - base); end
    checks++; if (w1_par !== 1'b1) begin errors++; $display("FAIL w1_bit: got %b expected 1", w1_par); end
    checks++; if (w1_en !== 1'b1) begin errors++; $display("FAIL w1_enable: got %b expected 1", w1_en); end
    tick();
    checks++; if ({w1_done, w1_busy, w1_ready} !== 3'b001) begin errors++; $display("FAIL w1_after: got %b expected 001", {w1_done, w1_busy, w1_ready}); end
  endtask

  initial begin
    test_reset();
    test_msb_load();
    test_lsb_timing();
    test_back_to_back();
    test_reset_mid();
    test_no_blank();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
